// File: rtl/obi_host_mailbox.sv
// OBI subordinate mailbox: X-HEEP software pushes 32-bit result words into a FIFO
// that the host-side register file drains with show-ahead data and a pop strobe.
module obi_host_mailbox #(
    parameter int pDEPTH      = 8,
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         req,
    input  logic                         we,
    input  logic [3:0]                   be,
    input  logic [pADDR_WIDTH-1:0]       addr,
    input  logic [pDATA_WIDTH-1:0]       wdata,
    output logic                         gnt,
    output logic                         rvalid,
    output logic [pDATA_WIDTH-1:0]       rdata,
    output logic [pDATA_WIDTH-1:0]       O_data,
    output logic                         O_valid,
    input  logic                         I_pop,
    output logic [$clog2(pDEPTH):0]      O_count,
    output logic                         O_full
);

    localparam int PW = $clog2(pDEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   rvalid_q;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0] offset;
    logic       full, empty, push, pop, flush;
    logic       unused_bits;

    assign offset      = addr[3:2];
    assign unused_bits = ^{be[3:1], addr[pADDR_WIDTH-1:4], addr[1:0]};

    assign full  = (count_q == CW'(pDEPTH));
    assign empty = (count_q == '0);

    // Stall on the registered full flag, so a same-cycle pop never grants.
    assign gnt   = req & ~reset_i & ~(we & (offset == OFF_DATA) & full);
    assign push  = gnt & we & (offset == OFF_DATA);
    assign flush = gnt & we & (offset == OFF_CTRL) & be[0] & wdata[0];
    assign pop   = I_pop & ~empty;

    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        if (!we) begin
            case (offset)
                OFF_DATA:   if (!empty) rdata_d = mem_q[rd_ptr_q];
                OFF_STATUS: begin
                    rdata_d[CW-1:0] = count_q;
                    rdata_d[CW]     = empty;
                    rdata_d[CW+1]   = full;
                end
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            rvalid_q <= gnt;
            if (gnt)
                rdata_q <= rdata_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset_i)
            mem_q[wr_ptr_q] <= wdata;
    end

    // A response still in flight when reset rises is suppressed, not delivered.
    assign rvalid  = rvalid_q & ~reset_i;
    assign rdata   = rdata_q;
    assign O_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign O_valid = ~empty;
    assign O_count = count_q;
    assign O_full  = full;

endmodule
